// File: rtl/ff_conv_pkg.sv
// Shared types and excitation helper for the flip-flop conversion bank.
//   mode_e  : run-time flip-flop personality (D, T, JK, SR)
//   SR_*    : policy for SR with S=R=1
//   excite  : per-bit toggle from mode, primary/secondary input and state
package ff_conv_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'd0,
    MODE_T  = 2'd1,
    MODE_JK = 2'd2,
    MODE_SR = 2'd3
  } mode_e;

  localparam int unsigned SR_HOLD = 0;
  localparam int unsigned SR_SET  = 1;
  localparam int unsigned SR_RST  = 2;

  // Toggle needed so that q ^ t equals the selected flip-flop's next state.
  function automatic logic excite(input mode_e m, input logic a, input logic b,
                                  input logic q, input int unsigned pol);
    logic t;
    t = 1'b0;
    case (m)
      MODE_D:  t = a ^ q;
      MODE_T:  t = a;
      MODE_JK: t = (a & ~q) | (b & q);
      MODE_SR: begin
        case ({a, b})
          2'b10:   t = ~q;
          2'b01:   t = q;
          2'b11:   t = (pol == SR_SET) ? ~q : ((pol == SR_RST) ? q : 1'b0);
          default: t = 1'b0;
        endcase
      end
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ff_conv_bank_tff_cell.sv
// Single T flip-flop storage bit.
//   clk, rst_n : clock, async active-low reset (loads RST_VAL)
//   en         : update enable
//   t          : toggle request
//   q          : stored bit
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= q ^ t;
  end

endmodule

// File: rtl/ff_conv_bank.sv
// Bank of WIDTH run-time configurable flip-flops (D/T/JK/SR) built on T cells,
// with sticky invalid-SR flags and a saturating toggle counter.
//   clk, rst_n       : clock, async active-low reset
//   en               : update enable for q, inv_flag set and counter increment
//   mode_wr, mode_in : mode register write (independent of en)
//   a, b             : D/T/J/S and K/R inputs per channel
//   inv_clr, cnt_clr : clear inv_flag / toggle_cnt
//   q, mode, inv_flag, toggle_cnt : registered state
module ff_conv_bank
  import ff_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SR_POL = 0,
  parameter int unsigned RST_Q  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode_wr,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inv_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] inv_flag,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int unsigned PW = $clog2(WIDTH + 1);
  localparam int unsigned SW = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] inv_set;
  logic [PW-1:0]    pop;
  logic [SW-1:0]    cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  // Excitation: convert the active mode's inputs into per-bit toggles.
  always_comb begin
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = excite(mode_e'(mode), a[i], b[i], q[i], SR_POL);
    end
  end

  // Storage cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(.RST_VAL(1'(RST_Q))) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  // Mode register; the current edge still uses the old mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mode <= 2'(MODE_D);
    else if (mode_wr) mode <= mode_in;
  end

  // Sticky invalid-SR flags; a set on the clearing edge survives.
  assign inv_set = (en && (mode == 2'(MODE_SR))) ? (a & b) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_flag <= '0;
    else        inv_flag <= (inv_clr ? '0 : inv_flag) | inv_set;
  end

  // Saturating toggle count; sum is widened so it can never wrap.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(t[i]);
    end
    cnt_sum  = SW'(toggle_cnt) + SW'(pop);
    cnt_next = (cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       toggle_cnt <= '0;
    else if (cnt_clr) toggle_cnt <= '0;
    else if (en)      toggle_cnt <= cnt_next;
  end

endmodule

// File: tb/tb_ff_conv_bank.sv
// Bench for ff_conv_bank: three instances (SR_POL 0/1/2, different counter
// widths) share stimulus and are checked against a next-state reference model,
// a directed vector table, and hand-written reset sequences.
module tb_ff_conv_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned NI = 3;

  logic clk = 1'b0;
  logic rst_n, en, mode_wr, inv_clr, cnt_clr;
  logic [1:0] mode_in;
  logic [W-1:0] a, b;

  logic [W-1:0] q0, q1, q2, inv0, inv1, inv2;
  logic [1:0]   mode0, mode1, mode2;
  logic [3:0]   cnt0;
  logic [15:0]  cnt1;
  logic [5:0]   cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [W-1:0] mq[NI];
  logic [1:0]   mmode[NI];
  logic [W-1:0] minv[NI];
  longint       mcnt[NI];
  int           pol[NI];
  int           cw[NI];

  always #5 clk = ~clk;

  ff_conv_bank #(.WIDTH(W), .CNT_W(4), .SR_POL(0), .RST_Q(1)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
    .a(a), .b(b), .inv_clr(inv_clr), .cnt_clr(cnt_clr),
    .q(q0), .mode(mode0), .inv_flag(inv0), .toggle_cnt(cnt0));

  ff_conv_bank #(.WIDTH(W), .CNT_W(16), .SR_POL(1), .RST_Q(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
    .a(a), .b(b), .inv_clr(inv_clr), .cnt_clr(cnt_clr),
    .q(q1), .mode(mode1), .inv_flag(inv1), .toggle_cnt(cnt1));

  ff_conv_bank #(.WIDTH(W), .CNT_W(6), .SR_POL(2), .RST_Q(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
    .a(a), .b(b), .inv_clr(inv_clr), .cnt_clr(cnt_clr),
    .q(q2), .mode(mode2), .inv_flag(inv2), .toggle_cnt(cnt2));

  typedef struct {
    logic         en;
    logic         mode_wr;
    logic [1:0]   mode_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         inv_clr;
    logic         cnt_clr;
    logic [W-1:0] eq;
    logic [1:0]   emode;
    logic [W-1:0] einv;
    int           ecnt;
  } vec_t;

  vec_t tbl[18];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k] = '1; mmode[k] = 2'd0; minv[k] = '0; mcnt[k] = 0;
    end
  endtask

  // Next state from flip-flop truth tables; toggles are the bits that changed.
  task automatic model_step();
    logic [W-1:0] nq;
    longint cmax;
    int tog;
    for (int k = 0; k < NI; k++) begin
      nq = mq[k];
      if (en) begin
        for (int i = 0; i < W; i++) begin
          case (mmode[k])
            2'd0: nq[i] = a[i];
            2'd1: nq[i] = mq[k][i] ^ a[i];
            2'd2: begin
              if (a[i] && b[i])  nq[i] = ~mq[k][i];
              else if (a[i])     nq[i] = 1'b1;
              else if (b[i])     nq[i] = 1'b0;
            end
            default: begin
              if (a[i] && b[i]) begin
                if (pol[k] == 1)      nq[i] = 1'b1;
                else if (pol[k] == 2) nq[i] = 1'b0;
              end
              else if (a[i]) nq[i] = 1'b1;
              else if (b[i]) nq[i] = 1'b0;
            end
          endcase
        end
      end
      tog  = $countones(nq ^ mq[k]);
      cmax = (longint'(1) << cw[k]) - 1;
      minv[k] = (inv_clr ? '0 : minv[k]) | ((en && mmode[k] == 2'd3) ? (a & b) : '0);
      if (cnt_clr)  mcnt[k] = 0;
      else if (en)  mcnt[k] = (mcnt[k] + tog > cmax) ? cmax : mcnt[k] + tog;
      if (mode_wr)  mmode[k] = mode_in;
      mq[k] = nq;
    end
  endtask

  task automatic check_inst(input string tag, input int k, input logic [W-1:0] aq,
                            input logic [1:0] am, input logic [W-1:0] ainv,
                            input logic [63:0] acnt);
    cmp($sformatf("%s u%0d q", tag, k), 64'(aq), 64'(mq[k]));
    cmp($sformatf("%s u%0d mode", tag, k), 64'(am), 64'(mmode[k]));
    cmp($sformatf("%s u%0d inv_flag", tag, k), 64'(ainv), 64'(minv[k]));
    cmp($sformatf("%s u%0d toggle_cnt", tag, k), acnt, 64'(mcnt[k]));
  endtask

  task automatic check_all(input string tag);
    check_inst(tag, 0, q0, mode0, inv0, 64'(cnt0));
    check_inst(tag, 1, q1, mode1, inv1, 64'(cnt1));
    check_inst(tag, 2, q2, mode2, inv2, 64'(cnt2));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    pol[0] = 0; pol[1] = 1; pol[2] = 2;
    cw[0]  = 4; cw[1]  = 16; cw[2] = 6;

    //            en wr md  a      b      ic cc  eq     em    einv   ecnt
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 2'd0, 8'h00, 0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 8'hA5, 2'd0, 8'h00, 4};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hA5, 2'd0, 8'h00, 4};
    tbl[3]  = '{1'b1, 1'b1, 2'd1, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h0F, 2'd1, 8'h00, 8};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h00, 2'd1, 8'h00, 12};
    tbl[5]  = '{1'b1, 1'b1, 2'd3, 8'h0F, 8'h00, 1'b0, 1'b0, 8'h0F, 2'd3, 8'h00, 15};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hF0, 2'd3, 8'h00, 15};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0, 8'hF0, 2'd3, 8'h01, 15};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 8'h02, 8'h02, 1'b1, 1'b0, 8'hF0, 2'd3, 8'h02, 15};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hF0, 2'd3, 8'h02, 0};
    tbl[10] = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0, 8'hF0, 2'd2, 8'h02, 0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h0F, 2'd2, 8'h02, 8};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hF0, 2'd2, 8'h02, 15};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hF0, 2'd2, 8'h02, 0};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h0F, 2'd2, 8'h02, 8};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h0F, 2'd2, 8'h00, 8};
    tbl[16] = '{1'b1, 1'b1, 2'd3, 8'h00, 8'h0F, 1'b0, 1'b0, 8'h00, 2'd3, 8'h00, 12};
    tbl[17] = '{1'b1, 1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 2'd3, 8'hFF, 12};

    rst_n = 1'b1; en = 1'b0; mode_wr = 1'b0; mode_in = 2'd0;
    a = '0; b = '0; inv_clr = 1'b0; cnt_clr = 1'b0;

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp("reset q", 64'(q0), 64'hFF);
    cmp("reset mode", 64'(mode0), 64'h0);
    cmp("reset inv_flag", 64'(inv0), 64'h0);
    cmp("reset toggle_cnt", 64'(cnt0), 64'h0);
    check_all("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table against the SR_POL=0, CNT_W=4 instance
    for (int v = 0; v < 18; v++) begin
      en = tbl[v].en; mode_wr = tbl[v].mode_wr; mode_in = tbl[v].mode_in;
      a = tbl[v].a; b = tbl[v].b; inv_clr = tbl[v].inv_clr; cnt_clr = tbl[v].cnt_clr;
      step();
      cmp($sformatf("vec%0d q", v), 64'(q0), 64'(tbl[v].eq));
      cmp($sformatf("vec%0d mode", v), 64'(mode0), 64'(tbl[v].emode));
      cmp($sformatf("vec%0d inv_flag", v), 64'(inv0), 64'(tbl[v].einv));
      cmp($sformatf("vec%0d toggle_cnt", v), 64'(cnt0), 64'(tbl[v].ecnt));
      check_all($sformatf("vec%0d", v));
    end

    // SR with S=R=1 under set- and reset-dominant policies
    cmp("srpol1 q", 64'(q1), 64'hFF);
    cmp("srpol2 q", 64'(q2), 64'h00);

    // Randomized run against the reference model
    for (int n = 0; n < 400; n++) begin
      en      = ($urandom_range(0, 3) != 0);
      mode_wr = ($urandom_range(0, 7) == 0);
      mode_in = 2'($urandom_range(0, 3));
      a       = 8'($urandom);
      b       = 8'($urandom);
      inv_clr = ($urandom_range(0, 15) == 0);
      cnt_clr = ($urandom_range(0, 31) == 0);
      step();
      check_all($sformatf("rnd%0d", n));
    end

    // Mid-operation reset, then first update must be D mode
    mode_wr = 1'b1; mode_in = 2'd2; en = 1'b1; a = 8'h55; b = 8'hAA;
    step();
    mode_wr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp("midreset q", 64'(q0), 64'hFF);
    cmp("midreset mode", 64'(mode1), 64'h0);
    check_all("midreset");
    @(posedge clk);
    #1;
    check_all("midreset_hold");
    rst_n = 1'b1; en = 1'b1; a = 8'h3C; b = 8'hFF; inv_clr = 1'b0; cnt_clr = 1'b0;
    step();
    cmp("postreset D q", 64'(q2), 64'h3C);
    check_all("postreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ff_conv_bank.md
# ff_conv_bank

Parametrised bank of WIDTH flip-flop channels that all share one T-flip-flop storage core. Each channel behaves as a D, T, JK or SR flip-flop, selected at run time through a registered mode. Excitation logic converts the selected mode's inputs into a per-bit toggle. The block also keeps a sticky per-channel flag for invalid SR input (S=R=1) and a saturating count of bit toggles. It is the generalised successor to the single-bit SR-on-T converter and serves as a general state-bit bank in control paths.

## Interface
- WIDTH, 8: number of channels (1..64).
- CNT_W, 16: toggle counter width (>= 1).
- SR_POL, 0: policy for SR with S=R=1. 0 = hold, 1 = set-dominant, 2 = reset-dominant.
- RST_Q, 0: reset value loaded into every q bit (0 or 1, replicated).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  update enable. When 0, q, inv_flag set and counter increment are all frozen.
- mode_wr  in  1  write strobe for the mode register.
- mode_in  in  2  new mode: 0 = D, 1 = T, 2 = JK, 3 = SR.
- a  in  WIDTH  per channel: D / T / J / S input.
- b  in  WIDTH  per channel: K / R input; ignored in D and T modes.
- inv_clr  in  1  clears all inv_flag bits.
- cnt_clr  in  1  clears toggle_cnt.
- q  out  WIDTH  channel state.
- mode  out  2  current mode.
- inv_flag  out  WIDTH  sticky flag: S=R=1 was applied with en=1 in SR mode.
- toggle_cnt  out  CNT_W  saturating count of q bits that toggled.

## Operation
- Reset values (rst_n=0, asynchronous): q = {WIDTH{RST_Q}}, mode = 0 (D), inv_flag = 0, toggle_cnt = 0.
- Per-bit toggle t[i] is combinational from mode, a[i], b[i] and q[i]:
  - D: t = a ^ q.
  - T: t = a.
  - JK: t = (a & ~q) | (b & q).
  - SR, S=0 and R=0: t = 0.
  - SR, S=1 and R=0: t = ~q.
  - SR, S=0 and R=1: t = q.
  - SR, S=1 and R=1: SR_POL 0 gives t = 0; 1 gives t = ~q; 2 gives t = q.
- At the clock edge with en=1: q <= q ^ t. With en=0: q holds.
- Mode register: on the edge where mode_wr=1, mode <= mode_in. This is independent of en.
- The q update on a mode_wr edge uses the old mode. The new mode applies from the next edge.
- inv_flag[i]:
  - Set on an edge where en=1, mode=SR, a[i]=1 and b[i]=1.
  - inv_clr=1 clears all bits on that edge.
  - Set and clear on the same edge: set wins for that bit.
- toggle_cnt:
  - On an edge with en=1: toggle_cnt <= min(toggle_cnt + popcount(t), 2^CNT_W - 1).
  - Compute the sum at CNT_W + clog2(WIDTH+1) bits before saturating. No wrap-around, ever.
  - cnt_clr=1 loads 0 and discards that cycle's increment.

## Timing
- All outputs are registered. q, mode, inv_flag and toggle_cnt change only at a rising clk edge, or immediately on rst_n falling.
- Latency: inputs sampled at edge N appear on outputs after edge N. A mode write becomes visible on mode after edge N and first governs the edge N+1 update.
- Reset asserted mid-operation clears all state asynchronously. The first update after rst_n deasserts uses D mode.
- There is no handshake. en is a qualifier only.

## Structure
- Shared package ff_conv_pkg holds:
  - the mode enum (MODE_D, MODE_T, MODE_JK, MODE_SR);
  - the SR_POL constants (SR_HOLD, SR_SET, SR_RST).
- Sub-module tff_cell: one bit, with ports clk, rst_n, en, t and q, plus a reset-value parameter. Instantiate it WIDTH times in a generate loop.
- The top level holds the excitation logic, the mode register, the flags and the counter.

## Test plan
- Reset: WIDTH=8, RST_Q=1, pulse rst_n low between edges -> immediately q=8'hFF, mode=0, inv_flag=0, toggle_cnt=0.
- D mode: q=8'h00, a=8'hA5, en=1 -> after 1 edge q=8'hA5, toggle_cnt=4. Then en=0 with a=8'h00 -> q stays 8'hA5.
- Mode switch: q=8'hA5, mode_wr=1, mode_in=T, a=8'h0F on the same edge -> q=8'h0F (D mode still applied), mode=1. Next edge with a=8'h0F -> q=8'h00.
- SR with SR_POL=0: q=8'h0F, a=8'hF0, b=8'h0F -> q=8'hF0. Then a=b=8'h01 -> q holds at 8'hF0, inv_flag=8'h01. inv_clr=1 with a=b=8'h02 on the same edge -> inv_flag=8'h02.
- JK saturation: CNT_W=4, a=b=8'hFF for 2 edges -> toggle_cnt goes 8, then 15 (saturated, not 0). cnt_clr=1 -> 0.
- JK with SR_POL=1 vs 2 (one bench run per parameter value), SR mode, q=8'h00, a=b=8'hFF -> SR_POL=1 gives q=8'hFF; SR_POL=2 gives q=8'h00.
